// File: rtl/isw_rand_pkg.sv
// -----------------------------------------------------------------------------
// isw_rand_pkg
// Shared definitions for the fresh-randomness source that feeds the 3-share
// ISW masked AND gadget: FSM state encoding, LFSR defaults, and the single
// Fibonacci LFSR step used by the combinational 3-step advance.
// -----------------------------------------------------------------------------
package isw_rand_pkg;

    typedef enum logic [1:0] {
        ST_UNSEEDED = 2'd0,
        ST_WARMUP   = 2'd1,
        ST_RUN      = 2'd2
    } rs_state_t;

    localparam int          LFSR_W_DEF = 32;
    localparam logic [31:0] TAPS_DEF   = 32'h8020_0003;

    // Widest LFSR the step function supports; narrower states are carried
    // zero-extended so the upper bits never reach the feedback.
    localparam int LFSR_MAX_W = 64;

    // One step: fb = ^(s & taps); s' = {fb, s[w-1:1]}.
    // The feedback bit is placed with a shifted mask rather than an indexed
    // write so the function stays width-generic.
    function automatic logic [LFSR_MAX_W-1:0] lfsr_step(
        input logic [LFSR_MAX_W-1:0] s,
        input logic [LFSR_MAX_W-1:0] taps,
        input int                    w
    );
        logic                  fb;
        logic [LFSR_MAX_W-1:0] fb_mask;
        fb      = ^(s & taps);
        fb_mask = {{(LFSR_MAX_W-1){1'b0}}, fb} << (w - 1);
        return (s >> 1) | fb_mask;
    endfunction

endpackage

// File: rtl/isw_rand_lfsr3.sv
// -----------------------------------------------------------------------------
// isw_rand_lfsr3
// Purely combinational 3-step advance of the Fibonacci LFSR (s -> s''').
// After the advance bits [2:0] hold the old bits [5:3], which have never been
// exposed on the random outputs.
// Ports:
//   cur  in   LFSR_W  current LFSR state
//   nxt  out  LFSR_W  state after three single steps
// -----------------------------------------------------------------------------
module isw_rand_lfsr3
    import isw_rand_pkg::*;
#(
    parameter int                LFSR_W = LFSR_W_DEF,
    parameter logic [LFSR_W-1:0] TAPS   = LFSR_W'(TAPS_DEF)
) (
    input  logic [LFSR_W-1:0] cur,
    output logic [LFSR_W-1:0] nxt
);

    logic [LFSR_MAX_W-1:0] s;
    logic [LFSR_MAX_W-1:0] t;

    always_comb begin
        s               = '0;
        t               = '0;
        s[LFSR_W-1:0]   = cur;
        t[LFSR_W-1:0]   = TAPS;
        s               = lfsr_step(s, t, LFSR_W);
        s               = lfsr_step(s, t, LFSR_W);
        s               = lfsr_step(s, t, LFSR_W);
        nxt             = s[LFSR_W-1:0];
    end

endmodule

// File: rtl/isw_rand_source.sv
// -----------------------------------------------------------------------------
// isw_rand_source
// Fresh-randomness stage upstream of the 3-share ISW AND gadget. A seedable
// Fibonacci LFSR is warmed up after every seed load and then hands out one
// never-exposed bit triple (r01, r02, r12) per accepted valid/ready transfer.
// Ports:
//   clk         in   1       clock, rising edge
//   rst_n       in   1       asynchronous active-low reset
//   seed_valid  in   1       load seed_data at the next edge (beats everything)
//   seed_data   in   LFSR_W  seed value; zero is replaced by one
//   rnd_valid   out  1       triple on r01/r02/r12 is valid
//   rnd_ready   in   1       consumer accepts the triple
//   r01/r02/r12 out  1       state[0] / state[1] / state[2]
//   busy        out  1       warm-up in progress
// -----------------------------------------------------------------------------
module isw_rand_source
    import isw_rand_pkg::*;
#(
    parameter int                LFSR_W = LFSR_W_DEF,
    parameter logic [LFSR_W-1:0] TAPS   = LFSR_W'(TAPS_DEF),
    parameter int                WARMUP = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              seed_valid,
    input  logic [LFSR_W-1:0] seed_data,
    output logic              rnd_valid,
    input  logic              rnd_ready,
    output logic              r01,
    output logic              r02,
    output logic              r12,
    output logic              busy
);

    localparam int CNT_W = (WARMUP > 1) ? $clog2(WARMUP + 1) : 1;

    rs_state_t         fsm, fsm_nxt;
    logic [LFSR_W-1:0] state, state_nxt, state_adv;
    logic [CNT_W-1:0]  cnt, cnt_nxt;

    isw_rand_lfsr3 #(
        .LFSR_W (LFSR_W),
        .TAPS   (TAPS)
    ) u_lfsr3 (
        .cur (state),
        .nxt (state_adv)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm   <= ST_UNSEEDED;
            state <= '0;
            cnt   <= '0;
        end else begin
            fsm   <= fsm_nxt;
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        fsm_nxt   = fsm;
        state_nxt = state;
        cnt_nxt   = cnt;
        if (seed_valid) begin
            // Reseed wins over any pending handshake or warm-up advance;
            // a triple offered this cycle is not consumed.
            state_nxt = (seed_data == '0) ? LFSR_W'(1) : seed_data;
            cnt_nxt   = CNT_W'(WARMUP);
            fsm_nxt   = (WARMUP == 0) ? ST_RUN : ST_WARMUP;
        end else begin
            case (fsm)
                ST_WARMUP: begin
                    state_nxt = state_adv;
                    cnt_nxt   = cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        fsm_nxt = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (rnd_ready) begin
                        state_nxt = state_adv;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign rnd_valid = (fsm == ST_RUN);
    assign busy      = (fsm == ST_WARMUP);
    assign r01       = state[0];
    assign r02       = state[1];
    assign r12       = state[2];

endmodule
